// File: rtl/datapath_function_unit.sv
// Execute stage behind the 8x16 register file. It takes the A/B read operands and a
// function select, and it returns a registered write-back beat (D_Data/DA/RW) plus status flags.
// ALU and shift ops finish in one edge. Multiply is a shift-add loop that runs for WORD_WIDTH
// iterations and holds BUSY high while it runs.
module datapath_function_unit #(
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [3:0]            FS,
  input  logic [WORD_WIDTH-1:0] A_Data,
  input  logic [WORD_WIDTH-1:0] B_Data,
  input  logic [2:0]            DA_In,
  input  logic                  WE_In,
  output logic                  BUSY,
  output logic [WORD_WIDTH-1:0] D_Data,
  output logic [2:0]            DA,
  output logic                  RW,
  output logic                  VALID,
  output logic                  V,
  output logic                  C,
  output logic                  N,
  output logic                  Z
);

  localparam int W = WORD_WIDTH;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MUL  = 1'b1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(W - 1);
  localparam logic [3:0] FS_MUL = 4'hF;

  // Control / multiply state
  logic                 r_state;
  logic [2*W-1:0]       r_mcand;
  logic [W-1:0]         r_mplier;
  logic [2*W-1:0]       r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_da_lat;
  logic                 r_we_lat;

  // Output registers
  logic [W-1:0] r_d;
  logic [2:0]   r_da;
  logic         r_rw;
  logic         r_valid;
  logic         r_v, r_c, r_n, r_z;

  // Combinational ALU
  logic [W-1:0] w_beff;
  logic         w_cin;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;

  // Multiply step
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_nxt;
  logic [W-1:0]   w_mul_lo;
  logic           w_mul_hi_nz;

  // Pick the effective second adder operand and carry-in for arithmetic ops 0-7
  always_comb begin
    w_beff = '0;
    w_cin  = 1'b0;
    case (FS)
      4'h1: w_cin = 1'b1;
      4'h2: w_beff = B_Data;
      4'h3: begin w_beff = B_Data;  w_cin = 1'b1; end
      4'h4: w_beff = ~B_Data;
      4'h5: begin w_beff = ~B_Data; w_cin = 1'b1; end
      4'h6: w_beff = '1;
      default: ;
    endcase
  end

  assign w_sum = {1'b0, A_Data} + {1'b0, w_beff} + {{W{1'b0}}, w_cin};

  // Result and carry/overflow for single-cycle ops; V compares the operand signs with the result sign
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (FS)
      4'h8: w_res = A_Data & B_Data;
      4'h9: w_res = A_Data | B_Data;
      4'hA: w_res = A_Data ^ B_Data;
      4'hB: w_res = ~A_Data;
      4'hC: w_res = B_Data;
      4'hD: begin w_res = {1'b0, B_Data[W-1:1]}; w_c = B_Data[0];   end
      4'hE: begin w_res = {B_Data[W-2:0], 1'b0}; w_c = B_Data[W-1]; end
      default: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (A_Data[W-1] == w_beff[W-1]) && (w_sum[W-1] != A_Data[W-1]);
      end
    endcase
  end

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt   = r_acc + w_addend;
  assign w_mul_lo    = w_acc_nxt[W-1:0];
  assign w_mul_hi_nz = |w_acc_nxt[2*W-1:W];

  // Issue/multiply sequencing. The write-back and flags are registered here, and RW/VALID are one-cycle pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_da_lat <= '0;
      r_we_lat <= 1'b0;
      r_d      <= '0;
      r_da     <= '0;
      r_rw     <= 1'b0;
      r_valid  <= 1'b0;
      r_v      <= 1'b0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_rw    <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            if (FS == FS_MUL) begin
              r_mcand  <= {{W{1'b0}}, A_Data};
              r_mplier <= B_Data;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_da_lat <= DA_In;
              r_we_lat <= WE_In;
              r_state  <= ST_MUL;
            end else begin
              r_d     <= w_res;
              r_da    <= DA_In;
              r_rw    <= WE_In;
              r_valid <= 1'b1;
              r_c     <= w_c;
              r_v     <= w_v;
              r_n     <= w_res[W-1];
              r_z     <= (w_res == '0);
            end
          end
        end
        default: begin
          // START is deliberately ignored here, including on the completing edge
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_WIDTH'(1);
          if (r_cnt == LAST_CNT) begin
            r_d     <= w_mul_lo;
            r_da    <= r_da_lat;
            r_rw    <= r_we_lat;
            r_valid <= 1'b1;
            r_c     <= w_mul_hi_nz;
            r_v     <= w_mul_hi_nz;
            r_n     <= w_mul_lo[W-1];
            r_z     <= (w_mul_lo == '0);
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign BUSY   = (r_state == ST_MUL);
  assign D_Data = r_d;
  assign DA     = r_da;
  assign RW     = r_rw;
  assign VALID  = r_valid;
  assign V      = r_v;
  assign C      = r_c;
  assign N      = r_n;
  assign Z      = r_z;

endmodule

// File: tb/tb_datapath_function_unit.sv
// Directed and randomized bench for datapath_function_unit (default 16-bit configuration).
module tb_datapath_function_unit;
  localparam int W = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [3:0]    FS;
  logic [W-1:0]  A_Data, B_Data;
  logic [2:0]    DA_In;
  logic          WE_In;
  logic          BUSY;
  logic [W-1:0]  D_Data;
  logic [2:0]    DA;
  logic          RW, VALID, V, C, N, Z;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected held output state
  logic [15:0] e_d;
  logic [2:0]  e_da;
  logic        e_v, e_c, e_n, e_z;

  always #5 CLK = ~CLK;

  datapath_function_unit #(.WORD_WIDTH(16), .CNT_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .FS(FS), .A_Data(A_Data), .B_Data(B_Data),
    .DA_In(DA_In), .WE_In(WE_In), .BUSY(BUSY), .D_Data(D_Data), .DA(DA), .RW(RW),
    .VALID(VALID), .V(V), .C(C), .N(N), .Z(Z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] obs_vec();
    return {7'b0, D_Data, DA, RW, VALID, V, C, N, Z};
  endfunction

  function automatic logic [31:0] exp_vec(input logic rw, input logic vld);
    return {7'b0, e_d, e_da, rw, vld, e_v, e_c, e_n, e_z};
  endfunction

  // Reference model: integer arithmetic; V means the signed result left the 16-bit range
  task automatic ref_alu(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, s, sv;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    s = 0; sv = 0; c = 1'b0;
    case (fs)
      4'h0, 4'h7: s = ua;
      4'h1: begin s = ua + 1;            c = (s > 65535); sv = sa + 1;      end
      4'h2: begin s = ua + ub;           c = (s > 65535); sv = sa + sb;     end
      4'h3: begin s = ua + ub + 1;       c = (s > 65535); sv = sa + sb + 1; end
      4'h4: begin s = ua + (65535 - ub); c = (s > 65535); sv = sa - sb - 1; end
      4'h5: begin s = ua - ub;           c = (ua >= ub);  sv = sa - sb;     end
      4'h6: begin s = ua - 1;            c = (ua != 0);   sv = sa - 1;      end
      4'h8: s = ua & ub;
      4'h9: s = ua | ub;
      4'hA: s = ua ^ ub;
      4'hB: s = 65535 - ua;
      4'hC: s = ub;
      4'hD: begin s = ub / 2; c = (ub % 2) == 1; end
      4'hE: begin s = (ub * 2) % 65536; c = (ub >= 32768); end
      default: s = 0;
    endcase
    v = (sv > 32767) || (sv < -32768);
    r = s[15:0];
  endtask

  // Issue one single-cycle op (called #1 after an edge) and check the write-back beat
  task automatic do_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] da, input logic we, input string tag);
    logic [15:0] r;
    logic c, v;
    ref_alu(fs, a, b, r, c, v);
    START = 1'b1; FS = fs; A_Data = a; B_Data = b; DA_In = da; WE_In = we;
    @(posedge CLK); #1;
    START = 1'b0; A_Data = 16'($urandom); B_Data = 16'($urandom);
    e_d = r; e_da = da; e_c = c; e_v = v; e_n = r[15]; e_z = (r == 16'h0);
    chk(tag, obs_vec(), exp_vec(we, 1'b1));
  endtask

  task automatic idle_chk(input string tag);
    @(posedge CLK); #1;
    chk(tag, obs_vec(), exp_vec(1'b0, 1'b0));
  endtask

  // Multiply with stray STARTs mid-busy and on the completing edge
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [2:0] da,
                        input logic we, input string tag);
    longint p;
    logic [15:0] lo;
    logic hi;
    int cyc, busy_cnt, disturb;
    p  = longint'(a) * longint'(b);
    lo = p[15:0];
    hi = ((p >> 16) != 0);
    START = 1'b1; FS = 4'hF; A_Data = a; B_Data = b; DA_In = da; WE_In = we;
    @(posedge CLK); #1;
    START = 1'b0;
    busy_cnt = (BUSY === 1'b1) ? 1 : 0;
    cyc = 0; disturb = 0;
    while (VALID !== 1'b1 && cyc < 40) begin
      START = (cyc == 6 || cyc == 15);
      FS = (cyc == 15) ? 4'h0 : 4'h2;
      A_Data = 16'($urandom); B_Data = 16'($urandom); DA_In = 3'($urandom); WE_In = 1'b1;
      @(posedge CLK); #1;
      cyc++;
      START = 1'b0;
      if (BUSY === 1'b1) busy_cnt++;
      if (VALID !== 1'b1 && obs_vec() !== exp_vec(1'b0, 1'b0)) disturb++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd16);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd16);
    chk({tag, " quiet while busy"}, 32'(disturb), 32'd0);
    e_d = lo; e_da = da; e_c = hi; e_v = hi; e_n = lo[15]; e_z = (lo == 16'h0);
    chk({tag, " result"}, obs_vec(), exp_vec(we, 1'b1));
    @(posedge CLK); #1;
    chk({tag, " after"}, {31'b0, BUSY}, 32'd0);
    chk({tag, " held"}, obs_vec(), exp_vec(1'b0, 1'b0));
  endtask

  initial begin
    int seen;
    RST = 1'b1; START = 1'b0; FS = 4'h0; A_Data = '0; B_Data = '0; DA_In = '0; WE_In = 1'b0;
    e_d = '0; e_da = '0; e_v = 1'b0; e_c = 1'b0; e_n = 1'b0; e_z = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset busy", {31'b0, BUSY}, 32'd0);
    chk("reset outputs", obs_vec(), 32'd0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // Subtract, then the one-cycle pulse drops
    do_op(4'h5, 16'h0005, 16'h0007, 3'd3, 1'b1, "sub");
    idle_chk("sub pulse end");

    // Add overflow / carry / compare, issued back-to-back
    do_op(4'h2, 16'h7FFF, 16'h0001, 3'd1, 1'b1, "add ovf");
    do_op(4'h2, 16'hFFFF, 16'h0001, 3'd2, 1'b1, "add carry");
    do_op(4'h5, 16'h1234, 16'h1234, 3'd4, 1'b0, "compare");

    // Shifts and logic
    do_op(4'hD, 16'h1111, 16'h0003, 3'd5, 1'b1, "shr");
    do_op(4'hE, 16'h1111, 16'h8001, 3'd6, 1'b1, "shl");
    do_op(4'h8, 16'hF0F0, 16'h3C3C, 3'd7, 1'b1, "and");
    idle_chk("flags hold");

    // Multiplies
    do_mul(16'h0123, 16'h0010, 3'd2, 1'b1, "mul");
    do_mul(16'h0100, 16'h0100, 3'd3, 1'b1, "mul ovf");
    do_mul(16'hFFFF, 16'hFFFF, 3'd4, 1'b1, "mul ffff");

    // Reset part-way through a multiply
    START = 1'b1; FS = 4'hF; A_Data = 16'h1234; B_Data = 16'h5678; DA_In = 3'd1; WE_In = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #3; RST = 1'b1;
    #1;
    chk("async reset busy", {31'b0, BUSY}, 32'd0);
    chk("async reset outputs", obs_vec(), 32'd0);
    e_d = '0; e_da = '0; e_v = 1'b0; e_c = 1'b0; e_n = 1'b0; e_z = 1'b0;
    @(negedge CLK); RST = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (VALID !== 1'b0 || RW !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    chk("no write-back after reset", 32'(seen), 32'd0);
    do_op(4'h1, 16'h00FF, 16'h0000, 3'd6, 1'b1, "inc after reset");

    // Randomized single-cycle ops
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom), 3'($urandom),
            1'($urandom), "rand alu");
      if (i % 8 == 7) idle_chk("rand idle");
    end

    // Randomized multiplies
    for (int i = 0; i < 3; i++)
      do_mul(16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), "rand mul");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
